ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB-Lite subordinate (responder) fronting a word-organised on-chip SRAM.
- Sits behind the bus controller: receives one decoder select line plus the shared slave-input signals, and returns read data, ready and response into that device's slot of the read mux.
- Supports byte, halfword and word transfers, programmable wait states, and the two-cycle ERROR response.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, ≥ 2.
- WAIT_STATES, 0, extra cycles with hreadyout=0 inserted in every OKAY data phase; range 0..15.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- hsel  input  1  select from the address decoder.
- haddr  input  32  transfer address, address phase.
- hwrite  input  1  1 = write, address phase.
- htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hsize  input  2  00 = byte, 01 = half, 10 = word.
- hready  input  1  global HREADY; previous data phase is complete.
- hwdata  input  32  write data, data phase.
- hrdata  output  32  read data, valid when hreadyout=1 in a read data phase.
- hreadyout  output  1  this slave's data phase is complete.
- hresp  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (async, rst=0): state IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, latched address-phase registers cleared. SRAM contents are not reset.
- A reset mid-transfer aborts the transfer; no write commits.
- Accept condition: on a rising clk, the address phase is accepted when hsel & hready & htrans[1]=1.
  - Latched: word index ((haddr-BASE_ADDR)>>2) mod DEPTH_WORDS, haddr[1:0], hwrite, hsize.
- IDLE/BUSY transfers, or hsel=0 with hready=1: no action, and the next cycle is a zero-wait OKAY (hreadyout=1, hresp=0).
- States:
  - IDLE: not in a data phase. hreadyout=1, hresp=0.
    - Accepted transfer with WAIT_STATES=0 → DATA.
    - Accepted transfer with WAIT_STATES>0 → WAIT, counter=WAIT_STATES.
    - Accepted transfer that is illegal (see Optional Feature) → ERR1.
  - WAIT: hreadyout=0, hresp=0. Counter decrements each cycle; → DATA when the counter reaches 1.
  - DATA: hreadyout=1, hresp=0. Final data-phase cycle.
    - Read: hrdata = mem[latched index], shifted so the bytes land in their native lanes.
    - Write: on the clock edge ending DATA, hwdata commits with byte enables:
      - byte: lane haddr[1:0];
      - half: lanes {2·haddr[1], 2·haddr[1]+1};
      - word: all four lanes.
    - Transitions: accepted transfer → WAIT / DATA / ERR1 as from IDLE; otherwise → IDLE.
  - ERR1: hreadyout=0, hresp=1. → ERR2 unconditionally.
  - ERR2: hreadyout=1, hresp=1. No memory access. Next state follows the same rules as DATA.
- Data-phase latency: an accepted transfer completes exactly WAIT_STATES+1 cycles after its address phase.
- hrdata is 0 whenever the slave is not in a read DATA state.
- Back-to-back write then read of the same word with WAIT_STATES=0: the read returns the newly written data, because the write commits before the read data phase.
- Pipelined address phases that arrive while hready=0 are ignored; the master must hold them.
- A master changing htrans during ERR1 has no effect; ERR2 always follows.
- Address offset is computed modulo 2^32. With the feature disabled, the index wraps modulo DEPTH_WORDS.

Optional Feature:
- Macro: AHB_SRAM_ERR_CHECK_EN.
- Defined: an accepted transfer is illegal, and takes the two-cycle ERROR path with no write, when any of the following holds:
  - offset ≥ DEPTH_WORDS·4;
  - misaligned: half with haddr[0]=1, or word with haddr[1:0]≠0;
  - hsize=11.
- Undefined: ERROR is never generated and hresp is tied to 0.
  - Out-of-range addresses wrap.
  - Misaligned accesses align down: half clears bit 0, word clears bits 1:0.
  - hsize=11 is treated as word.

Test Plan:
1. Reset mid-write: WAIT_STATES=3, NONSEQ write 0xDEADBEEF to BASE+0x10, assert rst in the 2nd wait cycle → immediately hreadyout=1, hresp=0, hrdata=0; a later read of 0x10 returns the pre-existing value.
2. Zero-wait write/read: WAIT_STATES=0, word write 0x12345678 @BASE+0x8, immediately followed by a pipelined read @BASE+0x8 → read data phase is the next cycle with hreadyout=1, hrdata=0x12345678.
3. Byte/half lanes: word-write 0 @0x4, byte-write 0xAA @0x6 (hwdata=0x00AA0000), half-write 0xBEEF @0x4 → word read @0x4 = 0x00AABEEF.
4. Wait states: WAIT_STATES=2, read → hreadyout low for exactly 2 cycles, high on the 3rd with valid data; IDLE transfers in between give zero-wait OKAY.
5. ERROR (feature defined): DEPTH_WORDS=1024, word read @BASE+0x1000 → one cycle hreadyout=0/hresp=1, then hreadyout=1/hresp=1; a word write @BASE+0x2 also errors and memory is unchanged. With the feature undefined, @BASE+0x1000 aliases word 0.
6. Deselect: hsel=0 with NONSEQ, and hsel=1 with hready=0 → no state change, no write, hreadyout stays 1.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate in front of a word-organised SRAM with programmable wait states.
// Define AHB_SRAM_ERR_CHECK_EN to turn out-of-range, misaligned and hsize=11 transfers into ERROR responses.
module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [1:0]  hsize,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lo_q, lo_d;
  logic [1:0]    size_q, size_d;
  logic          write_q, write_d;
  logic          hreadyout_q, hreadyout_d;
  logic          hresp_q, hresp_d;
  logic [31:0]   hrdata_q, hrdata_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept_s, illegal_s, wr_en_s, hit_s, go_data_s, rd_next_s;
  logic [31:0]   offset_s, wmask_s, rd_word_s;
  logic [AW-1:0] new_idx_s, rd_idx_s;
  logic          unused_s;

  // Halfword uses only addr[1] and word ignores addr[1:0], so misaligned accesses align down.
  function automatic logic [3:0] lane_mask(input logic [1:0] lo, input logic [1:0] size);
    case (size)
      2'b00:   lane_mask = 4'b0001 << lo;
      2'b01:   lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] bit_mask(input logic [3:0] be);
    bit_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  assign offset_s  = haddr - BASE_ADDR;
  assign new_idx_s = offset_s[AW+1:2];
  assign accept_s  = hsel & hready & htrans[1];
  assign wr_en_s   = (state_q == S_DATA) & write_q;
  assign wmask_s   = bit_mask(lane_mask(lo_q, size_q));
  assign unused_s  = ^{offset_s[31:AW+2], offset_s[1:0], htrans[0]};

`ifdef AHB_SRAM_ERR_CHECK_EN
  assign illegal_s = ({2'b00, offset_s} >= (34'(DEPTH_WORDS) << 2)) |
                     (hsize == 2'b11) |
                     ((hsize == 2'b01) & haddr[0]) |
                     ((hsize == 2'b10) & (haddr[1:0] != 2'b00));
`else
  assign illegal_s = 1'b0;
`endif

  // A write committing on the same edge that launches a read of that word is forwarded.
  assign hit_s     = wr_en_s & (idx_q == rd_idx_s);
  assign rd_word_s = hit_s ? ((mem[rd_idx_s] & ~wmask_s) | (hwdata & wmask_s)) : mem[rd_idx_s];

  // Next-state, latched address phase and next registered bus outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    size_d    = size_q;
    write_d   = write_q;
    go_data_s = 1'b0;
    rd_next_s = 1'b0;
    rd_idx_s  = idx_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d   = S_DATA;
          go_data_s = 1'b1;
          rd_next_s = ~write_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (accept_s) begin
          idx_d   = new_idx_s;
          lo_d    = haddr[1:0];
          size_d  = hsize;
          write_d = hwrite;
          if (illegal_s) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d   = S_DATA;
            go_data_s = 1'b1;
            rd_next_s = ~hwrite;
            rd_idx_s  = new_idx_s;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    hreadyout_d = (state_d == S_IDLE) | (state_d == S_DATA) | (state_d == S_ERR2);
    hresp_d     = (state_d == S_ERR1) | (state_d == S_ERR2);
    hrdata_d    = (go_data_s & rd_next_s) ? rd_word_s : 32'h0000_0000;
  end

  // Control and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      lo_q        <= 2'b00;
      size_q      <= 2'b00;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      size_q      <= size_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // SRAM array is not reset; writes commit on the edge that ends the write data phase.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[idx_q] <= (mem[idx_q] & ~wmask_s) | (hwdata & wmask_s);
    end
  end

  assign hrdata    = hrdata_q;
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances (0, 2 and 3 wait states) on one bus,
// checked every cycle against a transaction-level timeline and memory model.
module tb_ahb_sram_slave;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int NC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  hsel;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [1:0]  htrans, hsize;
  logic        hready, hready_force_low;
  logic [31:0] rdata [3];
  logic        ro [3];
  logic        rs [3];

  assign hready = hready_force_low ? 1'b0 : (ro[0] & ro[1] & ro[2]);

  ahb_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .hsel(hsel[0]), .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hready(hready), .hwdata(hwdata), .hrdata(rdata[0]), .hreadyout(ro[0]), .hresp(rs[0]));
  ahb_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_STATES(2)) u2 (
    .clk(clk), .rst(rst), .hsel(hsel[1]), .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hready(hready), .hwdata(hwdata), .hrdata(rdata[1]), .hreadyout(ro[1]), .hresp(rs[1]));
  ahb_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst), .hsel(hsel[2]), .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hready(hready), .hwdata(hwdata), .hrdata(rdata[2]), .hreadyout(ro[2]), .hresp(rs[2]));

  always #5 clk = ~clk;

  int          ws [3] = '{0, 2, 3};
  logic [31:0] mdl [3][1024];
  bit          exp_ro [3][NC];
  bit          exp_rs [3][NC];
  logic [31:0] exp_rd [3][NC];
  logic [31:0] wdat_sched [NC];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          chk_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Every cycle, each instance must show exactly the outputs the timeline predicts.
  always @(negedge clk) begin
    if (chk_en && cyc < NC) begin
      for (int i = 0; i < 3; i++) begin
        check32($sformatf("hreadyout%0d@%0d", i, cyc), {31'b0, ro[i]}, {31'b0, exp_ro[i][cyc]});
        check32($sformatf("hresp%0d@%0d", i, cyc), {31'b0, rs[i]}, {31'b0, exp_rs[i][cyc]});
        check32($sformatf("hrdata%0d@%0d", i, cyc), rdata[i], exp_rd[i][cyc]);
      end
    end
  end

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[31:2]) % 1024;
  endfunction

  function automatic bit illegal(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] off;
    off = a - BASE;
`ifdef AHB_SRAM_ERR_CHECK_EN
    return (off >= 32'd4096) || (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`else
    return (off == 32'd0) && (off != 32'd0);
`endif
  endfunction

  task automatic mdl_write(input int inst, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int  w;
    bit  on;
    w = idx_of(a);
    for (int b = 0; b < 4; b++) begin
      if (sz == 2'b00) on = (b == int'(a[1:0]));
      else if (sz == 2'b01) on = ((b / 2) == int'(a[1]));
      else on = 1'b1;
      if (on) mdl[inst][w][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < NC) hwdata = wdat_sched[cyc];
  endtask

  task automatic go_idle();
    hsel = 3'b000; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 2'b00;
  endtask

  task automatic idle(input int n);
    go_idle();
    repeat (n) tick();
  endtask

  // Present one NONSEQ address phase, hold it until hready, and record its predicted data phase.
  task automatic xfer(input int inst, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, input bit commit);
    int n = 0;
    int c;
    hsel = 3'b000; hsel[inst] = 1'b1;
    haddr = a; hwrite = wr; htrans = 2'b10; hsize = sz;
    while (hready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check32("hready_timeout", 32'(n), 32'd0);
    c = cyc;
    if (c + ws[inst] + 2 < NC) begin
      if (illegal(a, sz)) begin
        exp_ro[inst][c+1] = 1'b0; exp_rs[inst][c+1] = 1'b1;
        exp_ro[inst][c+2] = 1'b1; exp_rs[inst][c+2] = 1'b1;
      end else begin
        for (int k = 1; k <= ws[inst]; k++) exp_ro[inst][c+k] = 1'b0;
        if (wr) begin
          for (int k = 1; k <= ws[inst] + 1; k++) wdat_sched[c+k] = wd;
          if (commit) mdl_write(inst, a, sz, wd);
        end else begin
          exp_rd[inst][c+ws[inst]+1] = mdl[inst][idx_of(a)];
        end
      end
    end
    tick();
    go_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < NC; k++) begin
        exp_ro[i][k] = 1'b1; exp_rs[i][k] = 1'b0; exp_rd[i][k] = 32'h0;
      end
    for (int k = 0; k < NC; k++) wdat_sched[k] = 32'h0;
    hready_force_low = 1'b0;
    hwdata = 32'h0;
    go_idle();
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      check32($sformatf("reset_hreadyout%0d", i), {31'b0, ro[i]}, 32'd1);
      check32($sformatf("reset_hresp%0d", i), {31'b0, rs[i]}, 32'd0);
      check32($sformatf("reset_hrdata%0d", i), rdata[i], 32'h0);
    end
    rst = 1'b1;
    chk_en = 1'b1;
    tick();

    // Zero-wait write then pipelined read of the same word.
    xfer(0, 1'b1, BASE + 32'h8, 2'b10, 32'h1234_5678, 1'b1);
    xfer(0, 1'b0, BASE + 32'h8, 2'b10, 32'h0, 1'b1);
    check32("wr_rd_b2b_data", rdata[0], 32'h1234_5678);
    check32("wr_rd_b2b_model", exp_rd[0][cyc], 32'h1234_5678);
    idle(1);

    // Byte and halfword lanes.
    xfer(0, 1'b1, BASE + 32'h4, 2'b10, 32'h0000_0000, 1'b1);
    xfer(0, 1'b1, BASE + 32'h6, 2'b00, 32'h00AA_0000, 1'b1);
    xfer(0, 1'b1, BASE + 32'h4, 2'b01, 32'h0000_BEEF, 1'b1);
    xfer(0, 1'b0, BASE + 32'h4, 2'b10, 32'h0, 1'b1);
    check32("lanes_data", rdata[0], 32'h00AA_BEEF);
    check32("lanes_model", exp_rd[0][cyc], 32'h00AA_BEEF);
    idle(1);

    // Two wait states, pipelined read held off by hready, then IDLE/BUSY with hsel high.
    xfer(1, 1'b1, BASE + 32'h20, 2'b10, 32'h55AA_33CC, 1'b1);
    xfer(1, 1'b0, BASE + 32'h20, 2'b10, 32'h0, 1'b1);
    check32("ws2_wait1", {31'b0, ro[1]}, 32'd0);
    tick();
    check32("ws2_wait2", {31'b0, ro[1]}, 32'd0);
    tick();
    check32("ws2_done", {31'b0, ro[1]}, 32'd1);
    check32("ws2_data", rdata[1], 32'h55AA_33CC);
    hsel = 3'b010; htrans = 2'b00;
    tick();
    check32("ws2_idle_okay", {31'b0, ro[1]}, 32'd1);
    htrans = 2'b01;
    tick();
    check32("ws2_busy_okay", {31'b0, ro[1]}, 32'd1);
    idle(2);

    // Reset during the second wait state of a three-wait write.
    xfer(2, 1'b1, BASE + 32'h10, 2'b10, 32'hCAFE_F00D, 1'b1);
    idle(4);
    xfer(2, 1'b1, BASE + 32'h10, 2'b10, 32'hDEAD_BEEF, 1'b0);
    tick();
    for (int k = cyc; k < cyc + 8; k++) begin
      exp_ro[2][k] = 1'b1; exp_rs[2][k] = 1'b0; exp_rd[2][k] = 32'h0;
    end
    rst = 1'b0;
    #1;
    check32("rst_mid_hreadyout", {31'b0, ro[2]}, 32'd1);
    check32("rst_mid_hresp", {31'b0, rs[2]}, 32'd0);
    check32("rst_mid_hrdata", rdata[2], 32'h0);
    tick();
    rst = 1'b1;
    idle(2);
    xfer(2, 1'b0, BASE + 32'h10, 2'b10, 32'h0, 1'b1);
    idle(3);
    check32("rst_mid_no_commit", rdata[2], 32'hCAFE_F00D);
    idle(1);

    // Out-of-range, misaligned and hsize=11 transfers.
    xfer(0, 1'b1, BASE, 2'b10, 32'h0BAD_F00D, 1'b1);
    xfer(0, 1'b0, BASE + 32'h1000, 2'b10, 32'h0, 1'b1);
`ifdef AHB_SRAM_ERR_CHECK_EN
    check32("oor_err1", {30'b0, ro[0], rs[0]}, 32'd1);
    tick();
    check32("oor_err2", {30'b0, ro[0], rs[0]}, 32'd3);
`else
    check32("oor_alias", rdata[0], 32'h0BAD_F00D);
`endif
    idle(2);
    xfer(0, 1'b1, BASE + 32'h2, 2'b10, 32'h1111_2222, 1'b1);
    xfer(0, 1'b0, BASE, 2'b10, 32'h0, 1'b1);
`ifdef AHB_SRAM_ERR_CHECK_EN
    check32("misalign_no_write", rdata[0], 32'h0BAD_F00D);
`else
    check32("misalign_align_down", rdata[0], 32'h1111_2222);
`endif
    idle(2);
    xfer(0, 1'b1, BASE + 32'h30, 2'b10, 32'h0102_0304, 1'b1);
    xfer(0, 1'b1, BASE + 32'h30, 2'b11, 32'hA5A5_5A5A, 1'b1);
    xfer(0, 1'b0, BASE + 32'h30, 2'b10, 32'h0, 1'b1);
`ifdef AHB_SRAM_ERR_CHECK_EN
    check32("size11_no_write", rdata[0], 32'h0102_0304);
`else
    check32("size11_as_word", rdata[0], 32'hA5A5_5A5A);
`endif
    idle(2);
`ifndef AHB_SRAM_ERR_CHECK_EN
    xfer(0, 1'b1, BASE - 32'h4, 2'b10, 32'h7777_8888, 1'b1);
    xfer(0, 1'b0, BASE + 32'hFFC, 2'b10, 32'h0, 1'b1);
    check32("below_base_wrap", rdata[0], 32'h7777_8888);
    idle(2);
`endif

    // Deselected NONSEQ and selected NONSEQ under hready=0 are both ignored.
    hsel = 3'b000; htrans = 2'b10; hwrite = 1'b1; haddr = BASE + 32'h4; hsize = 2'b10;
    wdat_sched[cyc+1] = 32'hFFFF_FFFF;
    wdat_sched[cyc+2] = 32'hFFFF_FFFF;
    wdat_sched[cyc+3] = 32'hFFFF_FFFF;
    tick();
    check32("desel_hreadyout", {31'b0, ro[0]}, 32'd1);
    hsel = 3'b001;
    hready_force_low = 1'b1;
    tick();
    check32("nohready_hreadyout", {31'b0, ro[0]}, 32'd1);
    go_idle();
    hready_force_low = 1'b0;
    tick();
    xfer(0, 1'b0, BASE + 32'h4, 2'b10, 32'h0, 1'b1);
    check32("ignored_no_write", rdata[0], 32'h00AA_BEEF);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
